// File: rtl/seq_sum_product.sv
// Clocked sum/product stage with valid/ready handshakes.
// The product comes from a shift-add multiplier, one partial product per cycle.
module seq_sum_product #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   var1,
    input  logic [WIDTH-1:0]   var2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     sum,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] ILAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] term;
    logic [IW-1:0]      idx;
    logic               last;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, driven by state alone.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Current partial product: a shifted by the bit index, gated by b[idx].
    always_comb begin
        term = '0;
        if (b[idx]) begin
            term = {{WIDTH{1'b0}}, a} << idx;
        end
        last = (idx == ILAST);
    end

    // Operand latch, shift-add accumulation, result and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            idx      <= '0;
            sum      <= '0;
            product  <= '0;
            op_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a   <= var1;
                        b   <= var2;
                        sum <= {1'b0, var1} + {1'b0, var2};
                        acc <= '0;
                        idx <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (last) begin
                        product <= acc + term;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        op_count <= op_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sum_product.sv
// Directed and randomized bench for seq_sum_product.
// Expected values come from plain arithmetic on the operands.
module tb_seq_sum_product;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  var1 = '0;
    logic [7:0]  var2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  sum;
    logic [15:0] product;
    logic        busy;
    logic [7:0]  op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    seq_sum_product #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .var1(var1),
        .var2(var2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .product(product),
        .busy(busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_product", product, 0);
        chk("rst_op_count", op_count, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction: accept, count latency, optionally hold the result,
    // optionally keep offering new operands while the stage is busy.
    task automatic txn(input logic [7:0] v1, input logic [7:0] v2,
                       input int hold, input bit churn);
        int n;
        int lat;
        logic [8:0] es;
        logic [15:0] ep;
        es = 9'(v1) + 9'(v2);
        ep = 16'(v1) * 16'(v2);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        var1 = v1;
        var2 = v2;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        chk("busy_after_accept", busy, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            if (churn) begin
                var1 = 8'($urandom);
                var2 = 8'($urandom);
            end else begin
                in_valid = 1'b0;
                var1 = 8'($urandom);
                var2 = 8'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid) chk("in_ready_calc", in_ready, 0);
        end
        chk("latency", lat, 8);
        chk("sum", sum, es);
        chk("product", product, ep);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, es);
            chk("hold_product", product, ep);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("op_count", op_count, exp_cnt % 256);
        chk("idle_after_done", in_ready, 1);
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        do_reset();

        txn(8'd10, 8'd33, 0, 1'b0);
        txn(8'd132, 8'd33, 5, 1'b0);
        txn(8'd255, 8'd255, 0, 1'b0);
        txn(8'd0, 8'd200, 0, 1'b0);
        txn(8'd200, 8'd0, 2, 1'b0);
        txn(8'd1, 8'd128, 0, 1'b0);

        txn(8'd77, 8'd91, 0, 1'b1);
        chk("churn_not_consumed", busy, 0);

        // Abort a 7*9 operation on its 4th CALC cycle.
        @(negedge clk);
        var1 = 8'd7;
        var2 = 8'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_accept", busy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_op_count", op_count, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("abort_no_result", seen, 0);
        end

        for (int t = 0; t < 256; t++) begin
            txn(8'($urandom), 8'($urandom), 0, 1'b0);
        end
        chk("op_count_wrap", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
